// File: rtl/wb_rr_arbiter_b3.sv
// Round-robin arbiter that lets several Wishbone B3 masters share one slave, with a stall timeout that forces a bus error.
// Grant is one cycle after cyc is seen in IDLE; the slave stall is passed straight back to the owner until the timeout fires.
module wb_rr_arbiter_b3 #(
    parameter int MASTERS = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [MASTERS-1:0]      i_m_cyc,
    input  logic [MASTERS-1:0]      i_m_stb,
    input  logic [MASTERS*32-1:0]   i_m_adr,
    input  logic [MASTERS*32-1:0]   i_m_dat_m2s,
    input  logic [MASTERS*4-1:0]    i_m_sel,
    input  logic [MASTERS-1:0]      i_m_we,
    input  logic [MASTERS*3-1:0]    i_m_cti,
    input  logic [MASTERS-1:0]      i_m_bte,
    output logic [MASTERS*32-1:0]   o_m_dat_s2m,
    output logic [MASTERS-1:0]      o_m_ack,
    output logic [MASTERS-1:0]      o_m_err,
    output logic [MASTERS-1:0]      o_m_rty,
    output logic                    o_s_cyc,
    output logic                    o_s_stb,
    output logic                    o_s_we,
    output logic [31:0]             o_s_adr,
    output logic [31:0]             o_s_dat_m2s,
    output logic [3:0]              o_s_sel,
    output logic [2:0]              o_s_cti,
    output logic                    o_s_bte,
    input  logic [31:0]             i_s_dat_s2m,
    input  logic                    i_s_ack,
    input  logic                    i_s_err,
    input  logic                    i_s_rty,
    output logic [MASTERS-1:0]      o_gnt,
    output logic [7:0]              o_tmo_count
);

    localparam int PW = $clog2(MASTERS);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [PW-1:0] PTR_RST  = PW'(MASTERS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_TERR} state_t;

    state_t             r_state, w_state_nxt;
    logic [PW-1:0]      r_owner, w_owner_nxt;
    logic [PW-1:0]      r_ptr;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic [MASTERS-1:0] r_gnt, w_gnt_nxt;
    logic [7:0]         r_tmo;
    logic [PW-1:0]      w_search;
    logic               w_found;
    logic               w_sel_cyc, w_sel_stb, w_stall;

    // First requester at or after ptr+1, wrapping; earlier k wins.
    always_comb begin
        w_search = r_ptr;
        w_found  = 1'b0;
        for (int k = 1; k <= MASTERS; k++) begin
            for (int j = 0; j < MASTERS; j++) begin
                if (!w_found && i_m_cyc[j] && (j == (int'(r_ptr) + k) % MASTERS)) begin
                    w_found  = 1'b1;
                    w_search = PW'(j);
                end
            end
        end
    end

    always_comb begin
        w_sel_cyc   = 1'b0;
        w_sel_stb   = 1'b0;
        o_s_cyc     = 1'b0;
        o_s_stb     = 1'b0;
        o_s_we      = 1'b0;
        o_s_adr     = '0;
        o_s_dat_m2s = '0;
        o_s_sel     = '0;
        o_s_cti     = '0;
        o_s_bte     = 1'b0;
        o_m_dat_s2m = '0;
        o_m_ack     = '0;
        o_m_err     = '0;
        o_m_rty     = '0;
        for (int j = 0; j < MASTERS; j++) begin
            if (PW'(j) == r_owner) begin
                w_sel_cyc = i_m_cyc[j];
                w_sel_stb = i_m_stb[j];
                if (r_state == ST_GRANT) begin
                    o_s_cyc                = i_m_cyc[j];
                    o_s_stb                = i_m_stb[j];
                    o_s_we                 = i_m_we[j];
                    o_s_adr                = i_m_adr[j*32 +: 32];
                    o_s_dat_m2s            = i_m_dat_m2s[j*32 +: 32];
                    o_s_sel                = i_m_sel[j*4 +: 4];
                    o_s_cti                = i_m_cti[j*3 +: 3];
                    o_s_bte                = i_m_bte[j];
                    o_m_dat_s2m[j*32 +: 32] = i_s_dat_s2m;
                    o_m_ack[j]             = i_s_ack;
                    o_m_err[j]             = i_s_err;
                    o_m_rty[j]             = i_s_rty;
                end else if (r_state == ST_TERR) begin
                    o_m_err[j] = 1'b1;
                end
            end
        end
    end

    assign w_stall = (r_state == ST_GRANT) && w_sel_stb && !(i_s_ack || i_s_err || i_s_rty);

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        case (r_state)
            ST_IDLE: begin
                if (|i_m_cyc) begin
                    w_state_nxt = ST_GRANT;
                    w_owner_nxt = w_search;
                end
            end
            ST_GRANT: begin
                if (!w_sel_cyc)
                    w_state_nxt = ST_IDLE;
                else if ((TIMEOUT != 0) && w_stall && (r_cnt == CNT_LAST))
                    w_state_nxt = ST_TERR;
            end
            ST_TERR: begin
                w_state_nxt = w_sel_cyc ? ST_GRANT : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // A response in the last stalled cycle clears w_stall, so it is forwarded instead of erroring.
        w_cnt_nxt = '0;
        if ((TIMEOUT != 0) && w_stall && (w_state_nxt == ST_GRANT))
            w_cnt_nxt = r_cnt + 1'b1;

        w_gnt_nxt = '0;
        for (int j = 0; j < MASTERS; j++)
            w_gnt_nxt[j] = (w_state_nxt != ST_IDLE) && (PW'(j) == w_owner_nxt);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_ptr   <= PTR_RST;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
            if (r_state == ST_IDLE && w_state_nxt == ST_GRANT)
                r_ptr <= w_search;
            if (w_state_nxt == ST_TERR && r_tmo != 8'hFF)
                r_tmo <= r_tmo + 8'd1;
        end
    end

    assign o_gnt       = r_gnt;
    assign o_tmo_count = r_tmo;

endmodule

// File: tb/tb_wb_rr_arbiter_b3.sv
// Directed bench for wb_rr_arbiter_b3 with MASTERS=3, TIMEOUT=8: rotation, routed read, timeout, race and mid-transfer reset.
module tb_wb_rr_arbiter_b3;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  m_cyc, m_stb, m_we, m_bte;
    logic [95:0] m_adr, m_dat_m2s;
    logic [11:0] m_sel;
    logic [8:0]  m_cti;
    logic [95:0] m_dat_s2m;
    logic [2:0]  m_ack, m_err, m_rty;
    logic        s_cyc, s_stb, s_we, s_bte;
    logic [31:0] s_adr, s_dat_m2s;
    logic [3:0]  s_sel;
    logic [2:0]  s_cti;
    logic [31:0] s_dat_s2m;
    logic        s_ack, s_err, s_rty;
    logic [2:0]  gnt;
    logic [7:0]  tmo_count;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_rr_arbiter_b3 #(.MASTERS(3), .TIMEOUT(8)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_adr(m_adr), .i_m_dat_m2s(m_dat_m2s),
        .i_m_sel(m_sel), .i_m_we(m_we), .i_m_cti(m_cti), .i_m_bte(m_bte),
        .o_m_dat_s2m(m_dat_s2m), .o_m_ack(m_ack), .o_m_err(m_err), .o_m_rty(m_rty),
        .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_adr(s_adr),
        .o_s_dat_m2s(s_dat_m2s), .o_s_sel(s_sel), .o_s_cti(s_cti), .o_s_bte(s_bte),
        .i_s_dat_s2m(s_dat_s2m), .i_s_ack(s_ack), .i_s_err(s_err), .i_s_rty(s_rty),
        .o_gnt(gnt), .o_tmo_count(tmo_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 units after the edge; outputs are checked 1 unit later.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        m_cyc = '0; m_stb = '0; m_we = '0; m_bte = '0;
        m_adr = '0; m_dat_m2s = '0; m_sel = '0; m_cti = '0;
        s_dat_s2m = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        tick(2);
        rst = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_tmo", 32'(tmo_count), 32'h0);
        chk("rst_scyc", 32'(s_cyc), 32'h0);

        // Rotation: 001, 000, 010, 000, 100, 000, 001
        m_cyc = 3'b111;
        #1;
        chk("rot_idle_gnt", 32'(gnt), 32'h0);
        tick(1); #1;
        chk("rot_g0a", 32'(gnt), 32'b001);
        tick(1); #1;
        chk("rot_g0b", 32'(gnt), 32'b001);
        m_cyc = 3'b110;
        tick(1); #1;
        chk("rot_turn0", 32'(gnt), 32'b000);
        m_cyc = 3'b111;
        tick(1); #1;
        chk("rot_g1a", 32'(gnt), 32'b010);
        tick(1); #1;
        chk("rot_g1b", 32'(gnt), 32'b010);
        m_cyc = 3'b101;
        tick(1); #1;
        chk("rot_turn1", 32'(gnt), 32'b000);
        m_cyc = 3'b111;
        tick(1); #1;
        chk("rot_g2a", 32'(gnt), 32'b100);
        tick(1); #1;
        chk("rot_g2b", 32'(gnt), 32'b100);
        m_cyc = 3'b011;
        tick(1); #1;
        chk("rot_turn2", 32'(gnt), 32'b000);
        m_cyc = 3'b111;
        tick(1); #1;
        chk("rot_g0_again", 32'(gnt), 32'b001);
        m_cyc = 3'b000;
        tick(1); #1;
        chk("rot_idle_end", 32'(gnt), 32'b000);

        // Routed read by master 1
        m_cyc = 3'b010; m_stb = 3'b010;
        m_adr[63:32] = 32'h0000_0100; m_sel[7:4] = 4'hF; m_cti[5:3] = 3'b111;
        m_adr[31:0] = 32'hAAAA_0000; m_adr[95:64] = 32'hBBBB_0000;
        tick(1); #1;
        chk("rd_gnt", 32'(gnt), 32'b010);
        chk("rd_sadr", s_adr, 32'h0000_0100);
        chk("rd_ssel", 32'(s_sel), 32'hF);
        chk("rd_scti", 32'(s_cti), 32'h7);
        chk("rd_swe", 32'(s_we), 32'h0);
        chk("rd_sstb", 32'(s_stb), 32'h1);
        chk("rd_noack_early", 32'(m_ack), 32'h0);
        tick(2);
        s_ack = 1'b1; s_dat_s2m = 32'hDEADBEEF;
        #1;
        chk("rd_ack", 32'(m_ack), 32'b010);
        chk("rd_dat1", m_dat_s2m[63:32], 32'hDEADBEEF);
        chk("rd_dat0", m_dat_s2m[31:0], 32'h0);
        chk("rd_dat2", m_dat_s2m[95:64], 32'h0);
        tick(1);
        s_ack = 1'b0; s_dat_s2m = '0;
        m_cyc = 3'b000; m_stb = 3'b000;
        tick(1); #1;
        chk("rd_idle", 32'(gnt), 32'h0);

        // Timeout on master 2
        m_cyc = 3'b100; m_stb = 3'b100;
        tick(1); #1;
        chk("to_gnt", 32'(gnt), 32'b100);
        tick(7); #1;
        chk("to_last_stall_scyc", 32'(s_cyc), 32'h1);
        chk("to_last_stall_err", 32'(m_err), 32'h0);
        tick(1); #1;
        chk("to_terr_scyc", 32'(s_cyc), 32'h0);
        chk("to_terr_sstb", 32'(s_stb), 32'h0);
        chk("to_terr_err", 32'(m_err), 32'b100);
        chk("to_terr_ack", 32'(m_ack), 32'h0);
        chk("to_terr_tmo", 32'(tmo_count), 32'h1);
        chk("to_terr_gnt", 32'(gnt), 32'b100);
        tick(1); #1;
        chk("to_resume_scyc", 32'(s_cyc), 32'h1);
        chk("to_resume_err", 32'(m_err), 32'h0);
        chk("to_resume_gnt", 32'(gnt), 32'b100);

        // Race: ack arrives in the cnt=7 cycle
        tick(7);
        s_ack = 1'b1; s_dat_s2m = 32'h1234_5678;
        #1;
        chk("race_ack", 32'(m_ack), 32'b100);
        chk("race_dat2", m_dat_s2m[95:64], 32'h1234_5678);
        chk("race_err", 32'(m_err), 32'h0);
        tick(1);
        s_ack = 1'b0; s_dat_s2m = '0;
        #1;
        chk("race_after_scyc", 32'(s_cyc), 32'h1);
        chk("race_after_err", 32'(m_err), 32'h0);
        chk("race_after_tmo", 32'(tmo_count), 32'h1);
        m_cyc = 3'b000; m_stb = 3'b000;
        tick(1); #1;
        chk("race_idle", 32'(gnt), 32'h0);

        // Reset during master 0 stall at cnt=5
        m_cyc = 3'b001; m_stb = 3'b001;
        tick(1); #1;
        chk("mr_gnt", 32'(gnt), 32'b001);
        tick(5);
        rst = 1'b1;
        #1;
        chk("mr_rst_ack", 32'(m_ack), 32'h0);
        chk("mr_rst_err", 32'(m_err), 32'h0);
        tick(1);
        rst = 1'b0;
        #1;
        chk("mr_scyc", 32'(s_cyc), 32'h0);
        chk("mr_gnt0", 32'(gnt), 32'h0);
        chk("mr_tmo", 32'(tmo_count), 32'h0);
        chk("mr_ack", 32'(m_ack), 32'h0);
        chk("mr_err", 32'(m_err), 32'h0);
        tick(1); #1;
        chk("mr_regrant", 32'(gnt), 32'b001);
        chk("mr_regrant_err", 32'(m_err), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter_b3.md
WB_RR_ARBITER_B3 -- requirements
Module: wb_rr_arbiter_b3

Interface
REQ-001 Parameter MASTERS, default 3, number of Wishbone B3 masters sharing one slave port (range 2..8).
REQ-002 Parameter TIMEOUT, default 255, stalled-strobe cycles before a bus error is forced (0 disables the timeout).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 m_cyc, m_stb  in  MASTERS each  per-master cycle and strobe; index i belongs to master i.
REQ-006 m_adr, m_dat_m2s, m_sel, m_we, m_cti, m_bte  in  MASTERS x (32, 32, 4, 1, 3, 1)  packed per-master payload.
REQ-007 m_dat_s2m  out  MASTERS x 32  per-master read data.
REQ-008 m_ack, m_err, m_rty  out  MASTERS each  per-master termination.
REQ-009 s_cyc, s_stb, s_we, s_adr, s_dat_m2s, s_sel, s_cti, s_bte  out  1, 1, 1, 32, 32, 4, 3, 1  shared slave-side request.
REQ-010 s_dat_s2m, s_ack, s_err, s_rty  in  32, 1, 1, 1  shared slave-side response.
REQ-011 gnt  out  MASTERS  registered one-hot owner; all zero when no owner.
REQ-012 tmo_count  out  8  saturating count of forced timeouts.

Function
REQ-013 The FSM SHALL have states IDLE, GRANT and TERR.
REQ-014 IDLE: s_cyc = s_stb = 0, all other s_* outputs = 0, gnt = 0, and every m_ack/m_err/m_rty/m_dat_s2m = 0.
REQ-015 IDLE with any m_cyc set: the next edge SHALL enter GRANT.
  - Owner = first set m_cyc index searching upward, wrapping, from (ptr+1) mod MASTERS.
  - ptr is then loaded with owner.
REQ-016 Grant latency SHALL be exactly one cycle from m_cyc sampled high in IDLE to gnt/s_cyc valid.
REQ-017 GRANT routing:
  - All s_* request outputs = owner's m_* payload, combinationally.
  - Owner's m_dat_s2m/m_ack/m_err/m_rty = s_dat_s2m/s_ack/s_err/s_rty.
  - Non-owners receive all zeros.
REQ-018 GRANT SHALL be held while m_cyc[owner] = 1; requests from other masters SHALL NOT preempt.
REQ-019 GRANT with m_cyc[owner] = 0 SHALL return to IDLE for one turnaround cycle, even if other requests are pending.
REQ-020 Timeout counter cnt (width clog2(TIMEOUT+1)):
  - Increments each GRANT cycle with s_stb = 1 and s_ack = s_err = s_rty = 0.
  - Clears on any slave response, on s_stb = 0, and on leaving GRANT.
REQ-021 GRANT with cnt = TIMEOUT-1, still stalled and TIMEOUT != 0: the next edge SHALL enter TERR.
REQ-022 A slave response arriving in the cycle cnt = TIMEOUT-1 SHALL be forwarded normally, with no TERR.
REQ-023 TERR lasts exactly one cycle:
  - s_cyc = s_stb = 0.
  - m_err[owner] = 1; owner's m_ack/m_rty/m_dat_s2m = 0.
  - tmo_count increments, saturating at 255.
REQ-024 Leaving TERR: go to GRANT (same owner) if m_cyc[owner] = 1, else IDLE.
REQ-025 gnt SHALL equal one-hot(owner) in GRANT and TERR.

Reset
REQ-026 While rst = 1 at an edge, the block SHALL reset to:
  - state = IDLE, ptr = MASTERS-1 (master 0 wins first), cnt = 0, gnt = 0, tmo_count = 0.
  - All outputs take IDLE values from the following cycle.
REQ-027 Reset asserted mid-transaction SHALL abandon the transfer with no m_ack or m_err issued.

Verification (MASTERS=3, TIMEOUT=8)
REQ-028 Rotation: after reset, hold m_cyc = 3'b111 and drop each owner's cyc after 2 cycles -> gnt sequence 001, 000, 010, 000, 100, 000, 001.
REQ-029 Routed read: master1 alone reads adr 0x0000_0100; slave acks on the 3rd strobe cycle with 0xDEADBEEF -> m_ack = 3'b010, m_dat_s2m[1] = 0xDEADBEEF, masters 0 and 2 all zero.
REQ-030 Timeout: master2 strobes and the slave never responds -> after 8 stalled cycles, one TERR cycle with s_cyc = 0, m_err = 3'b100, tmo_count = 1; GRANT resumes since cyc is still high.
REQ-031 Race: slave acks in the cycle cnt = 7 -> ack forwarded, m_err stays 0, tmo_count unchanged.
REQ-032 Reset mid-transfer: rst = 1 for one cycle during master0 stall with cnt = 5 -> next cycle s_cyc = 0, gnt = 0, tmo_count = 0; no m_ack or m_err pulse.
